// File: rtl/iter_divider.sv
// Purpose: radix-2 restoring divider for DIV/DIVU; quotient on result_lo, remainder on result_hi.
// Latency: WIDTH+1 cycles from acceptance to the ready pulse (1 cycle when dividing by zero).
// Backpressure: div_stall holds the pipeline while busy; annul or rst abandon the operation.
module iter_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             annul,
  output logic             div_stall,
  output logic             ready,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  state_t           nextState;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [CNT_W-1:0] cnt;
  logic             quoNeg;
  logic             remNeg;

  logic             accept;
  logic             divByZero;
  logic             lastIter;
  logic [WIDTH-1:0] magA;
  logic [WIDTH-1:0] magB;
  logic [WIDTH:0]   shl;
  logic             borrow;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] remNext;
  logic [WIDTH-1:0] quoNext;

  assign accept    = (state == IDLE) && start && !annul;
  assign divByZero = (b == '0);
  assign lastIter  = (cnt == CNT_W'(WIDTH - 1));

  // Magnitudes are only taken for signed divides; the most negative value maps onto itself.
  assign magA = (signed_div && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
  assign magB = (signed_div && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;

  // One restoring step: the shifted remainder needs WIDTH+1 bits, but a successful
  // difference is always below the divisor, so the low WIDTH bits of the subtraction suffice.
  assign shl     = {rem, quo[WIDTH-1]};
  assign borrow  = (shl < {1'b0, divisor});
  assign diff    = shl[WIDTH-1:0] - divisor;
  assign remNext = borrow ? shl[WIDTH-1:0] : diff;
  assign quoNext = {quo[WIDTH-2:0], ~borrow};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // Next-state logic and stall request; the stall is dropped in DONE so EX can advance.
  always_comb begin
    nextState = state;
    div_stall = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          div_stall = 1'b1;
          nextState = divByZero ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (annul) begin
          nextState = IDLE;
        end else begin
          div_stall = 1'b1;
          if (lastIter) nextState = DONE;
        end
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
    // Reset must release the pipeline even while start is still held.
    if (rst) div_stall = 1'b0;
  end

  // Datapath: operand capture, iteration, and result registration on entry to DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      divisor   <= '0;
      quo       <= '0;
      rem       <= '0;
      cnt       <= '0;
      quoNeg    <= 1'b0;
      remNeg    <= 1'b0;
      ready     <= 1'b0;
      result_lo <= '0;
      result_hi <= '0;
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            divisor <= magB;
            quo     <= magA;
            rem     <= '0;
            cnt     <= '0;
            quoNeg  <= (a[WIDTH-1] ^ b[WIDTH-1]) & signed_div;
            remNeg  <= a[WIDTH-1] & signed_div;
            if (divByZero) begin
              // Fixed, deterministic result for the architecturally undefined case.
              result_lo <= '1;
              result_hi <= a;
              ready     <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (!annul) begin
            rem <= remNext;
            quo <= quoNext;
            cnt <= cnt + CNT_W'(1);
            if (lastIter) begin
              result_lo <= quoNeg ? (~quoNext + WIDTH'(1)) : quoNext;
              result_hi <= remNeg ? (~remNext + WIDTH'(1)) : remNext;
              ready     <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_divider.sv
// Purpose: scoreboard bench for iter_divider; directed vectors with hand-computed results.
// Latency: checks stall length per divide; results checked by a monitor on each ready pulse.
// Backpressure: start is held while div_stall is high, as the EX stage would.
module tb_iter_divider;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         signed_div = 1'b0;
  logic         annul = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         div_stall;
  logic         ready;
  logic [W-1:0] result_lo;
  logic [W-1:0] result_hi;

  int           passCnt = 0;
  int           totalCnt = 0;
  logic [2*W-1:0] expQ[$];
  logic [W-1:0] lastLo = '0;
  logic [W-1:0] lastHi = '0;

  iter_divider #(.WIDTH(W), .CNT_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .signed_div(signed_div),
    .a         (a),
    .b         (b),
    .annul     (annul),
    .div_stall (div_stall),
    .ready     (ready),
    .result_lo (result_lo),
    .result_hi (result_hi)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Monitor: every ready pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && ready) begin
      if (expQ.size() == 0) begin
        totalCnt++;
        $display("FAIL unexpected_ready: got ready=1 with lo=0x%08h hi=0x%08h, expected no result",
                 result_lo, result_hi);
      end else begin
        logic [2*W-1:0] e;
        e = expQ.pop_front();
        check("result_lo", result_lo, e[2*W-1:W]);
        check("result_hi", result_hi, e[W-1:0]);
      end
    end
  end

  // Issue one divide, hold start while stalled, and check the stall length.
  task automatic runDiv(input string name, input logic sd, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input logic [W-1:0] eLo,
                        input logic [W-1:0] eHi, input int eStall);
    int stallCnt;
    bit done;
    stallCnt = 0;
    done = 1'b0;
    expQ.push_back({eLo, eHi});
    lastLo = eLo;
    lastHi = eHi;
    signed_div = sd;
    a = av;
    b = bv;
    start = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (div_stall) begin
        stallCnt++;
        @(posedge clk);
        #1;
      end else begin
        done = 1'b1;
      end
    end
    check({name, " stall_cycles"}, W'(stallCnt), W'(eStall));
    check({name, " ready_after_stall"}, W'(ready), W'(1));
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    // Reset state, with start already asserted to show rst overrides the stall.
    #12;
    start = 1'b1;
    #1;
    check("reset div_stall", W'(div_stall), W'(0));
    check("reset ready", W'(ready), W'(0));
    check("reset result_lo", result_lo, '0);
    check("reset result_hi", result_hi, '0);
    start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    runDiv("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33);
    runDiv("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
    runDiv("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 33);
    runDiv("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 33);
    runDiv("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 33);
    runDiv("divu_5_0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1);

    // Annul at BUSY iteration 10.
    signed_div = 1'b0;
    a = 32'd1000;
    b = 32'd3;
    start = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    annul = 1'b1;
    #1;
    check("annul busy div_stall", W'(div_stall), W'(0));
    @(posedge clk);
    #1;
    annul = 1'b0;
    start = 1'b0;
    // Annul overriding start while idle.
    start = 1'b1;
    annul = 1'b1;
    #1;
    check("annul idle div_stall", W'(div_stall), W'(0));
    @(posedge clk);
    #1;
    start = 1'b0;
    annul = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("annul no ready", W'(ready), W'(0));
    check("annul result_lo held", result_lo, lastLo);
    check("annul result_hi held", result_hi, lastHi);
    @(posedge clk);
    #1;
    runDiv("divu_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33);

    // Asynchronous reset at BUSY iteration 20, start still held.
    signed_div = 1'b0;
    a = 32'd1000;
    b = 32'd3;
    start = 1'b1;
    repeat (20) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst div_stall", W'(div_stall), W'(0));
    check("rst ready", W'(ready), W'(0));
    check("rst result_lo", result_lo, '0);
    check("rst result_hi", result_hi, '0);
    start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Back-to-back divides.
    runDiv("divu_10_3", 1'b0, 32'd10, 32'd3, 32'd3, 32'd1, 33);
    runDiv("divu_20_6", 1'b0, 32'd20, 32'd6, 32'd3, 32'd2, 33);

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard drained", W'(expQ.size()), W'(0));

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
